duck_sprite_fetch: RTL and testbench
====================================

// Module: duck_sprite_fetch
// PURPOSE
//  Upstream feeder for the duck palette stage.
//  - Per VGA pixel, decides whether (DrawX,DrawY) falls inside the duck sprite box.
//  - Drives the sprite ROM address for the current animation frame and returns the
//    4-bit palette index with a valid flag, pipeline-aligned to the draw coordinates.
//  - Owns animation-frame sequencing and vsync-synchronous latching of duck position.
// PARAMETERS
//  SPRITE_W    32  sprite width in pixels (power of 2)
//  SPRITE_H    32  sprite height in pixels
//  NUM_FRAMES  3   animation frames stored back-to-back in ROM
//  FRAME_DIV   8   vsync periods per animation frame (>=1)
//  TRANSP_IDX  0   palette index treated as transparent
//  ADDR_W      $clog2(NUM_FRAMES*SPRITE_W*SPRITE_H)  ROM address width (derived)
// PORTS
//  Clk        in   1       pixel clock; all state on rising edge
//  Reset      in   1       asynchronous, active-high
//  vsync      in   1       VGA vsync, level (active-low pulse); edge-detected internally
//  DrawX      in   10      current pixel column
//  DrawY      in   10      current pixel row
//  duck_x     in   10      sprite left edge, live from game logic
//  duck_y     in   10      sprite top edge, live from game logic
//  anim_en    in   1       1 = advance animation; 0 = hold current frame
//  flip_h     in   1       1 = mirror sprite horizontally (duck faces left)
//  rom_addr   out  ADDR_W  sprite ROM address (ROM is synchronous, 1-cycle read)
//  rom_q      in   4       ROM data for rom_addr presented one edge earlier
//  pix_index  out  4       palette index to palette stage
//  pix_valid  out  1       1 = in box and index != TRANSP_IDX
//  anim_frame out  2       current animation frame (debug/game logic)
// BEHAVIOUR
//  Reset (async assert, sync-released by system):
//   - rom_addr=0, pix_index=0, pix_valid=0, anim_frame=0.
//   - Divider=0, latched pos=(0,0), vsync edge register=1, pipeline valid bits=0.
//  Frame event: vsync 1->0 transition, detected with one register. One-cycle pulse fe.
//   - On fe: latch pos_x<=duck_x, pos_y<=duck_y. Mid-frame position changes never tear.
//   - On fe with anim_en=1: div<=div+1. When div==FRAME_DIV-1: div<=0 and anim_frame advances.
//   - Frame advance wraps NUM_FRAMES-1 -> 0.
//   - anim_en=0: div and anim_frame hold. Latching still occurs.
//  Pipeline (edge E samples DrawX/DrawY):
//   - E:   col=DrawX-pos_x, row=DrawY-pos_y, both 11-bit with borrow.
//          in_box = no borrow && col<SPRITE_W && row<SPRITE_H.
//          Register rom_addr and v1=in_box.
//   - E+1: ROM registers rom_q. Carry v2<=v1.
//   - E+2: pix_index<=v2 ? rom_q : TRANSP_IDX. pix_valid<=v2 && rom_q!=TRANSP_IDX.
//   - Latency exactly 2 edges after sampling; the top level delays DrawX/DrawY to match.
//  Address arithmetic:
//   - rom_addr = anim_frame*SPRITE_W*SPRITE_H + row*SPRITE_W + c.
//   - c = flip_h ? SPRITE_W-1-col : col. Truncated to ADDR_W.
//   - When !in_box: rom_addr holds the previous value (no toggling, saves power). v1=0.
//  Boundaries:
//   - No wrap at screen edge. pos_x=1010, DrawX=5 -> borrow -> not in box.
//   - Pixels at DrawX>=1024-W beyond 1023 simply clip.
//   - fe coincident with in-box pixel: that pixel uses the pre-update pos and frame.
//     New values apply from the next edge.
//   - flip_h is sampled per pixel (not latched). Game logic changes it only during vblank.
//   - Reset mid-line: outputs go invalid immediately. First valid output is 2 edges after
//     the first post-reset in-box sample.
// TESTING
//  1 Reset: assert Reset mid-sprite -> pix_valid=0, anim_frame=0, rom_addr=0 same cycle.
//  2 Latency/addr: pos=(100,50) latched, DrawX=103, DrawY=52, frame 0, flip 0
//      -> rom_addr=67 one edge later.
//      -> pix_index=rom_q(67), pix_valid=(rom_q!=0) two edges after sampling.
//  3 Flip: same as 2 with flip_h=1 -> rom_addr=2*32+28=92.
//  4 Animation: anim_en=1, FRAME_DIV=8 -> frame 0->1 after 8 fe, 2 after 16, 0 after 24.
//      Second pass with anim_en=0 for 8 fe -> frame holds.
//  5 Tearing: change duck_x mid-frame -> in-box decision uses old pos until next fe.
//  6 Clip/borrow: pos_x=1010, DrawX=1015 -> valid. DrawX=5 -> pix_valid=0, pix_index=TRANSP_IDX.

Source files
------------

// File: rtl/duck_sprite_fetch.sv
// Duck sprite fetch: box test, sprite ROM addressing, animation sequencing and
// vsync-latched position. Palette index/valid emerge two edges after DrawX/DrawY sampling.
module duck_sprite_fetch #(
  parameter int          SPRITE_W   = 32,
  parameter int          SPRITE_H   = 32,
  parameter int          NUM_FRAMES = 3,
  parameter int          FRAME_DIV  = 8,
  parameter logic [3:0]  TRANSP_IDX = 4'd0,
  parameter int          ADDR_W     = $clog2(NUM_FRAMES * SPRITE_W * SPRITE_H)
) (
  input  logic              Clk,
  input  logic              Reset,
  input  logic              vsync,
  input  logic [9:0]        DrawX,
  input  logic [9:0]        DrawY,
  input  logic [9:0]        duck_x,
  input  logic [9:0]        duck_y,
  input  logic              anim_en,
  input  logic              flip_h,
  output logic [ADDR_W-1:0] rom_addr,
  input  logic [3:0]        rom_q,
  output logic [3:0]        pix_index,
  output logic              pix_valid,
  output logic [1:0]        anim_frame
);

  localparam int                DIV_W      = (FRAME_DIV > 1) ? $clog2(FRAME_DIV) : 1;
  localparam logic [DIV_W-1:0]  DIV_LAST   = DIV_W'(FRAME_DIV - 1);
  localparam logic [1:0]        FRAME_LAST = 2'(NUM_FRAMES - 1);
  localparam logic [10:0]       SW11       = 11'(SPRITE_W);
  localparam logic [10:0]       SH11       = 11'(SPRITE_H);
  localparam logic [ADDR_W-1:0] FRAME_SZ   = ADDR_W'(SPRITE_W * SPRITE_H);
  localparam logic [ADDR_W-1:0] ROW_SZ     = ADDR_W'(SPRITE_W);

  logic              vs_q;
  logic              fe;
  logic [9:0]        pos_x;
  logic [9:0]        pos_y;
  logic [DIV_W-1:0]  div_q;
  logic [DIV_W-1:0]  div_d;
  logic [1:0]        frame_q;
  logic [1:0]        frame_d;
  logic [10:0]       col;
  logic [10:0]       row;
  logic [10:0]       c;
  logic              in_box;
  logic [ADDR_W-1:0] addr_d;
  logic              v1;
  logic              v2;

  // Frame event: falling edge of vsync, one clock wide
  always_comb begin
    fe = vs_q & ~vsync;
  end

  always_ff @(posedge Clk or posedge Reset) begin
    if (Reset) begin
      vs_q  <= 1'b1;
      pos_x <= '0;
      pos_y <= '0;
    end else begin
      vs_q <= vsync;
      if (fe) begin
        pos_x <= duck_x;
        pos_y <= duck_y;
      end
    end
  end

  // Animation sequencer: state register / next-state / output
  always_ff @(posedge Clk or posedge Reset) begin
    if (Reset) begin
      div_q   <= '0;
      frame_q <= '0;
    end else begin
      div_q   <= div_d;
      frame_q <= frame_d;
    end
  end

  always_comb begin
    div_d   = div_q;
    frame_d = frame_q;
    if (fe && anim_en) begin
      if (div_q == DIV_LAST) begin
        div_d   = '0;
        frame_d = (frame_q == FRAME_LAST) ? 2'd0 : frame_q + 2'd1;
      end else begin
        div_d = div_q + DIV_W'(1);
      end
    end
  end

  always_comb begin
    anim_frame = frame_q;
  end

  // Box test and address; bit 10 of the 11-bit differences is the borrow
  always_comb begin
    col    = {1'b0, DrawX} - {1'b0, pos_x};
    row    = {1'b0, DrawY} - {1'b0, pos_y};
    in_box = !col[10] && !row[10] && (col < SW11) && (row < SH11);
    c      = flip_h ? (SW11 - 11'd1 - col) : col;
    addr_d = ADDR_W'(frame_q) * FRAME_SZ + ADDR_W'(row) * ROW_SZ + ADDR_W'(c);
  end

  // rom_addr only moves for in-box pixels so the ROM address bus stays quiet elsewhere
  always_ff @(posedge Clk or posedge Reset) begin
    if (Reset) begin
      rom_addr  <= '0;
      v1        <= 1'b0;
      v2        <= 1'b0;
      pix_index <= '0;
      pix_valid <= 1'b0;
    end else begin
      if (in_box) begin
        rom_addr <= addr_d;
      end
      v1        <= in_box;
      v2        <= v1;
      pix_index <= v2 ? rom_q : TRANSP_IDX;
      pix_valid <= v2 && (rom_q != TRANSP_IDX);
    end
  end

endmodule

// File: tb/tb_duck_sprite_fetch.sv
// Directed bench for duck_sprite_fetch; sprite ROM modelled with data = low nibble of address.
module tb_duck_sprite_fetch;

  logic        Clk;
  logic        Reset;
  logic        vsync;
  logic [9:0]  DrawX;
  logic [9:0]  DrawY;
  logic [9:0]  duck_x;
  logic [9:0]  duck_y;
  logic        anim_en;
  logic        flip_h;
  logic [11:0] rom_addr;
  logic [3:0]  rom_q;
  logic [3:0]  pix_index;
  logic        pix_valid;
  logic [1:0]  anim_frame;

  int n_tests = 0;
  int n_fail  = 0;

  duck_sprite_fetch #(
    .SPRITE_W   (32),
    .SPRITE_H   (32),
    .NUM_FRAMES (3),
    .FRAME_DIV  (8),
    .TRANSP_IDX (4'd0)
  ) dut (
    .Clk        (Clk),
    .Reset      (Reset),
    .vsync      (vsync),
    .DrawX      (DrawX),
    .DrawY      (DrawY),
    .duck_x     (duck_x),
    .duck_y     (duck_y),
    .anim_en    (anim_en),
    .flip_h     (flip_h),
    .rom_addr   (rom_addr),
    .rom_q      (rom_q),
    .pix_index  (pix_index),
    .pix_valid  (pix_valid),
    .anim_frame (anim_frame)
  );

  initial Clk = 1'b0;
  always #5 Clk = ~Clk;

  // Synchronous ROM, one-cycle read
  always_ff @(posedge Clk) rom_q <= rom_addr[3:0];

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge Clk);
    #1;
  endtask

  task automatic frame_event();
    vsync = 1'b0;
    tick();
    vsync = 1'b1;
    tick();
  endtask

  task automatic run_pixel(input string tag, input logic [9:0] x, input logic [9:0] y,
                           input logic f, input logic [11:0] exp_addr,
                           input logic [3:0] exp_idx, input logic exp_valid);
    DrawX  = x;
    DrawY  = y;
    flip_h = f;
    tick();
    check({tag, "_addr"}, 32'(rom_addr), 32'(exp_addr));
    tick();
    tick();
    check({tag, "_idx"}, 32'(pix_index), 32'(exp_idx));
    check({tag, "_valid"}, 32'(pix_valid), 32'(exp_valid));
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    Reset = 1'b1; vsync = 1'b1; DrawX = '0; DrawY = '0;
    duck_x = '0; duck_y = '0; anim_en = 1'b0; flip_h = 1'b0;
    tick();
    tick();
    check("rst_addr",  32'(rom_addr),   32'd0);
    check("rst_valid", 32'(pix_valid),  32'd0);
    check("rst_idx",   32'(pix_index),  32'd0);
    check("rst_frame", 32'(anim_frame), 32'd0);
    Reset = 1'b0;
    tick();

    // Latch position (100,50)
    duck_x = 10'd100; duck_y = 10'd50;
    frame_event();
    tick();

    // Latency and address: (103,52) -> 2*32+3 = 67, ROM data 3
    DrawX = 10'd103; DrawY = 10'd52;
    tick();
    check("lat_addr_e0",  32'(rom_addr),  32'd67);
    check("lat_valid_e0", 32'(pix_valid), 32'd0);
    DrawX = 10'd0;
    tick();
    check("lat_hold_e1",  32'(rom_addr),  32'd67);
    check("lat_valid_e1", 32'(pix_valid), 32'd0);
    tick();
    check("lat_idx_e2",   32'(pix_index), 32'd3);
    check("lat_valid_e2", 32'(pix_valid), 32'd1);
    tick();
    check("lat_idx_e3",   32'(pix_index), 32'd0);
    check("lat_valid_e3", 32'(pix_valid), 32'd0);

    run_pixel("flip",   10'd103, 10'd52, 1'b1, 12'd92,  4'd12, 1'b1);
    run_pixel("transp", 10'd100, 10'd52, 1'b0, 12'd64,  4'd0,  1'b0);
    run_pixel("col31",  10'd131, 10'd52, 1'b0, 12'd95,  4'd15, 1'b1);
    run_pixel("col32",  10'd132, 10'd52, 1'b0, 12'd95,  4'd0,  1'b0);
    run_pixel("row31",  10'd101, 10'd81, 1'b0, 12'd993, 4'd1,  1'b1);
    run_pixel("row32",  10'd101, 10'd82, 1'b0, 12'd993, 4'd0,  1'b0);

    // Animation: 8 frame events per animation step, wrap after 3 frames
    anim_en = 1'b1;
    repeat (7) frame_event();
    check("anim_7",  32'(anim_frame), 32'd0);
    frame_event();
    check("anim_8",  32'(anim_frame), 32'd1);
    repeat (8) frame_event();
    check("anim_16", 32'(anim_frame), 32'd2);
    run_pixel("frame2", 10'd103, 10'd52, 1'b0, 12'd2115, 4'd3, 1'b1);
    repeat (8) frame_event();
    check("anim_24", 32'(anim_frame), 32'd0);
    anim_en = 1'b0;
    repeat (8) frame_event();
    check("anim_hold", 32'(anim_frame), 32'd0);
    anim_en = 1'b1;
    repeat (7) frame_event();
    check("anim_div_held", 32'(anim_frame), 32'd0);
    frame_event();
    check("anim_resume", 32'(anim_frame), 32'd1);
    anim_en = 1'b0;

    // Tearing: duck_x moves mid-frame, frame 1 base = 1024
    duck_x = 10'd200;
    run_pixel("tear_old",     10'd103, 10'd52, 1'b0, 12'd1091, 4'd3, 1'b1);
    run_pixel("tear_new_out", 10'd205, 10'd52, 1'b0, 12'd1091, 4'd0, 1'b0);
    vsync = 1'b0;
    tick();
    check("fe_coincident", 32'(rom_addr), 32'd1091);
    vsync = 1'b1;
    tick();
    check("fe_after", 32'(rom_addr), 32'd1093);
    run_pixel("tear_new", 10'd205, 10'd52, 1'b0, 12'd1093, 4'd5, 1'b1);

    // Clip and borrow near the right screen edge
    duck_x = 10'd1010; duck_y = 10'd50;
    frame_event();
    run_pixel("clip_in",     10'd1015, 10'd53, 1'b0, 12'd1125, 4'd5,  1'b1);
    run_pixel("clip_borrow", 10'd5,    10'd53, 1'b0, 12'd1125, 4'd0,  1'b0);
    run_pixel("clip_edge",   10'd1023, 10'd53, 1'b0, 12'd1133, 4'd13, 1'b1);

    // Reset asserted mid-cycle while a valid sprite pixel is on the output
    #2;
    Reset = 1'b1;
    #1;
    check("rst_mid_valid", 32'(pix_valid),  32'd0);
    check("rst_mid_frame", 32'(anim_frame), 32'd0);
    check("rst_mid_addr",  32'(rom_addr),   32'd0);
    tick();
    Reset = 1'b0;
    DrawX = 10'd3; DrawY = 10'd2;
    tick();
    check("post_rst_addr",   32'(rom_addr),  32'd67);
    check("post_rst_valid0", 32'(pix_valid), 32'd0);
    tick();
    check("post_rst_valid1", 32'(pix_valid), 32'd0);
    tick();
    check("post_rst_idx",    32'(pix_index), 32'd3);
    check("post_rst_valid2", 32'(pix_valid), 32'd1);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
